// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported word memory between instruction fetch
// and load/store, with a grant/access/response pipeline and fetch-flush kill.
module mem_port_arbiter #(
   parameter int ADDR_W = 8
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_flush,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [31:0]       i_rdata,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [3:0]        d_wmask,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              m_en,
   output logic [ADDR_W-1:0] m_addr,
   output logic [3:0]        m_wmask,
   output logic [31:0]       m_wdata,
   input  logic [31:0]       m_rdata
);

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   owner_e              last_win_q, last_win_d;

   logic                a_valid_q, a_valid_d;
   owner_e              a_owner_q, a_owner_d;
   logic [ADDR_W-1:0]   a_addr_q,  a_addr_d;
   logic [3:0]          a_wmask_q, a_wmask_d;
   logic [31:0]         a_wdata_q, a_wdata_d;

   logic                r_valid_q, r_valid_d;
   owner_e              r_owner_q, r_owner_d;
   logic                r_kill_q,  r_kill_d;

   logic                grant_i, grant_d;

   // On contention the side that did not win last time is granted; grants stay low in reset.
   always_comb begin
      grant_i = RESETN & i_req & (~d_req | (last_win_q == OWN_D));
      grant_d = RESETN & d_req & (~i_req | (last_win_q == OWN_I));
   end

   assign i_gnt = grant_i;
   assign d_gnt = grant_d;

   // NOTE: every next-state signal gets a default first so no latch is inferred.
   always_comb begin
      last_win_d = last_win_q;
      a_valid_d  = grant_i | grant_d;
      a_owner_d  = a_owner_q;
      a_addr_d   = a_addr_q;
      a_wmask_d  = 4'b0000;
      a_wdata_d  = a_wdata_q;
      if (grant_i) begin
         last_win_d = OWN_I;
         a_owner_d  = OWN_I;
         a_addr_d   = i_addr;
      end else if (grant_d) begin
         last_win_d = OWN_D;
         a_owner_d  = OWN_D;
         a_addr_d   = d_addr;
         a_wmask_d  = d_wmask;
         a_wdata_d  = d_wdata;
      end
   end

   // A flush seen while an I access sits in A marks it killed as it moves into R.
   always_comb begin
      r_valid_d = a_valid_q;
      r_owner_d = a_owner_q;
      r_kill_d  = i_flush & (a_owner_q == OWN_I);
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         last_win_q <= OWN_D;
         a_valid_q  <= 1'b0;
         a_owner_q  <= OWN_I;
         a_addr_q   <= '0;
         a_wmask_q  <= 4'b0000;
         a_wdata_q  <= '0;
         r_valid_q  <= 1'b0;
         r_owner_q  <= OWN_I;
         r_kill_q   <= 1'b0;
      end else begin
         last_win_q <= last_win_d;
         a_valid_q  <= a_valid_d;
         a_owner_q  <= a_owner_d;
         a_addr_q   <= a_addr_d;
         a_wmask_q  <= a_wmask_d;
         a_wdata_q  <= a_wdata_d;
         r_valid_q  <= r_valid_d;
         r_owner_q  <= r_owner_d;
         r_kill_q   <= r_kill_d;
      end
   end

   assign m_en    = a_valid_q;
   assign m_addr  = a_addr_q;
   assign m_wmask = a_wmask_q;
   assign m_wdata = a_wdata_q;

   // A flush in the response cycle itself also suppresses the stale I response.
   assign i_rvalid = r_valid_q & (r_owner_q == OWN_I) & ~r_kill_q & ~i_flush;
   assign d_rvalid = r_valid_q & (r_owner_q == OWN_D);
   assign i_rdata  = m_rdata;
   assign d_rdata  = m_rdata;

endmodule
